// File: rtl/scam_evt_packer.sv
// Event packer behind the SCA block controller: stores each event's data words, appends a
// count/overflow trailer and an XOR checksum trailer, and presents them on a FWFT read port.
module scam_evt_packer #(
    parameter int TMR = 0,
    parameter int AW  = 7
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        PUSH,
    input  logic [15:0] DIN,
    input  logic        LASTWORD,
    input  logic        RD_EN,
    output logic [15:0] DOUT,
    output logic        DOUT_VLD,
    output logic        DOUT_LAST,
    output logic        EVT_AVAIL,
    output logic [3:0]  NEVT,
    output logic        FULL,
    output logic        OVFL,
    output logic        PROTERR,
    output logic [7:0]  DROPCNT
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_LIM   = (AW+1)'(DEPTH - 3);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_TRL1 = 3'd2,
        S_TRL2 = 3'd3,
        S_SKIP = 3'd4
    } state_t;

    function automatic logic [2:0] maj3_s(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [AW:0] maj3_w(input logic [AW:0] a, input logic [AW:0] b, input logic [AW:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t      w_state;
    state_t      w_state_nxt;
    logic [AW:0] w_evt_cnt;
    logic [AW:0] w_evt_cnt_nxt;

    logic [16:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_used;
    logic [11:0] r_cnt;
    logic [15:0] r_csum;
    logic        r_evt_ovf;
    logic [15:0] r_dout;
    logic        r_dout_vld;
    logic        r_dout_last;
    logic [3:0]  r_nevt;
    logic        r_evt_avail;
    logic        r_full;
    logic        r_ovfl;
    logic        r_proterr;
    logic [7:0]  r_dropcnt;

    logic [11:0] w_cnt_nxt;
    logic [15:0] w_csum_nxt;
    logic        w_evt_ovf_nxt;
    logic        w_wr_en;
    logic [16:0] w_wr_data;
    logic        w_set_ovfl;
    logic        w_set_proterr;
    logic        w_drop;
    logic        w_evt_done;
    logic        w_space;
    logic        w_pop;
    logic        w_pop_tag;
    logic [AW:0] w_rd_ptr_nxt;
    logic [AW:0] w_avail_nxt;
    logic [AW:0] w_used_nxt;

    generate
        if (TMR != 0) begin : g_tmr
            logic [2:0]  r_state_q [3];
            logic [AW:0] r_evt_q   [3];
            // Three copies of FSM state and event count, voted on every read
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    for (int k = 0; k < 3; k++) begin
                        r_state_q[k] <= S_IDLE;
                        r_evt_q[k]   <= '0;
                    end
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        r_state_q[k] <= w_state_nxt;
                        r_evt_q[k]   <= w_evt_cnt_nxt;
                    end
                end
            end
            assign w_state   = state_t'(maj3_s(r_state_q[0], r_state_q[1], r_state_q[2]));
            assign w_evt_cnt = maj3_w(r_evt_q[0], r_evt_q[1], r_evt_q[2]);
        end else begin : g_single
            state_t      r_state;
            logic [AW:0] r_evt;
            // Single-copy FSM state and event count
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    r_state <= S_IDLE;
                    r_evt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_evt   <= w_evt_cnt_nxt;
                end
            end
            assign w_state   = r_state;
            assign w_evt_cnt = r_evt;
        end
    endgenerate

    // Registered occupancy only: a same-cycle pop never buys room for a write
    assign w_space      = (r_used <= C_LIM);
    assign w_pop        = RD_EN & r_dout_vld;
    assign w_pop_tag    = w_pop & r_dout_last;
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + C_ONE) : r_rd_ptr;
    assign w_avail_nxt  = r_wr_ptr - w_rd_ptr_nxt;
    assign w_used_nxt   = r_used + (w_wr_en ? C_ONE : '0) - (w_pop ? C_ONE : '0);

    // Write FSM: next state, FIFO write request and per-event accumulators
    always_comb begin
        w_state_nxt   = w_state;
        w_cnt_nxt     = r_cnt;
        w_csum_nxt    = r_csum;
        w_evt_ovf_nxt = r_evt_ovf;
        w_wr_en       = 1'b0;
        w_wr_data     = 17'h0_0000;
        w_set_ovfl    = 1'b0;
        w_set_proterr = 1'b0;
        w_drop        = 1'b0;
        w_evt_done    = 1'b0;
        case (w_state)
            S_IDLE: begin
                if (PUSH && w_space) begin
                    w_wr_en       = 1'b1;
                    w_wr_data     = {1'b0, DIN};
                    w_cnt_nxt     = 12'd1;
                    w_csum_nxt    = DIN;
                    w_evt_ovf_nxt = 1'b0;
                    w_state_nxt   = LASTWORD ? S_TRL1 : S_DATA;
                end else if (PUSH) begin
                    w_drop      = 1'b1;
                    w_state_nxt = LASTWORD ? S_IDLE : S_SKIP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (PUSH) begin
                    w_cnt_nxt  = (r_cnt == 12'hFFF) ? r_cnt : (r_cnt + 12'd1);
                    w_csum_nxt = r_csum ^ DIN;
                    if (w_space) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = {1'b0, DIN};
                    end else begin
                        w_evt_ovf_nxt = 1'b1;
                        w_set_ovfl    = 1'b1;
                    end
                    w_state_nxt = LASTWORD ? S_TRL1 : S_DATA;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_TRL1: begin
                w_wr_en       = 1'b1;
                w_wr_data     = {1'b0, 3'b111, r_evt_ovf, r_cnt};
                w_set_proterr = PUSH;
                w_state_nxt   = S_TRL2;
            end
            S_TRL2: begin
                w_wr_en       = 1'b1;
                w_wr_data     = {1'b1, r_csum};
                w_set_proterr = PUSH;
                w_evt_done    = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            S_SKIP: begin
                if (PUSH && LASTWORD) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SKIP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Complete-event count: trailer write and tag pop in one cycle cancel out
    always_comb begin
        w_evt_cnt_nxt = w_evt_cnt;
        if (w_evt_done && !w_pop_tag) begin
            w_evt_cnt_nxt = w_evt_cnt + C_ONE;
        end else if (!w_evt_done && w_pop_tag) begin
            w_evt_cnt_nxt = w_evt_cnt - C_ONE;
        end else begin
            w_evt_cnt_nxt = w_evt_cnt;
        end
    end

    // Storage array, left unreset so it can map onto RAM
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    // Pointers, accumulators, sticky status and the registered FWFT read port
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_used      <= '0;
            r_cnt       <= 12'h000;
            r_csum      <= 16'h0000;
            r_evt_ovf   <= 1'b0;
            r_dout      <= 16'h0000;
            r_dout_vld  <= 1'b0;
            r_dout_last <= 1'b0;
            r_nevt      <= 4'h0;
            r_evt_avail <= 1'b0;
            r_full      <= 1'b0;
            r_ovfl      <= 1'b0;
            r_proterr   <= 1'b0;
            r_dropcnt   <= 8'h00;
        end else begin
            r_wr_ptr  <= w_wr_en ? (r_wr_ptr + C_ONE) : r_wr_ptr;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_used    <= w_used_nxt;
            r_cnt     <= w_cnt_nxt;
            r_csum    <= w_csum_nxt;
            r_evt_ovf <= w_evt_ovf_nxt;
            // Registered write pointer: a word only shows one cycle after its write
            if (w_avail_nxt != '0) begin
                r_dout      <= r_mem[w_rd_ptr_nxt[AW-1:0]][15:0];
                r_dout_last <= r_mem[w_rd_ptr_nxt[AW-1:0]][16];
                r_dout_vld  <= 1'b1;
            end else begin
                r_dout      <= 16'h0000;
                r_dout_last <= 1'b0;
                r_dout_vld  <= 1'b0;
            end
            r_nevt      <= (32'(w_evt_cnt_nxt) > 32'd15) ? 4'hF : 4'(w_evt_cnt_nxt);
            r_evt_avail <= (w_evt_cnt_nxt != '0);
            r_full      <= (w_used_nxt == C_DEPTH);
            r_ovfl      <= r_ovfl | w_set_ovfl;
            r_proterr   <= r_proterr | w_set_proterr;
            r_dropcnt   <= (w_drop && (r_dropcnt != 8'hFF)) ? (r_dropcnt + 8'd1) : r_dropcnt;
        end
    end

    assign DOUT      = r_dout;
    assign DOUT_VLD  = r_dout_vld;
    assign DOUT_LAST = r_dout_last;
    assign EVT_AVAIL = r_evt_avail;
    assign NEVT      = r_nevt;
    assign FULL      = r_full;
    assign OVFL      = r_ovfl;
    assign PROTERR   = r_proterr;
    assign DROPCNT   = r_dropcnt;

endmodule

// File: tb/tb_scam_evt_packer.sv
// Bench for scam_evt_packer: per-cycle vector tables plus directed sequences for overflow,
// dropped events, protocol errors and asynchronous reset. Plain and TMR builds run in lockstep.
`timescale 1ns/1ps
module tb_scam_evt_packer;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        push;
    logic [15:0] din;
    logic        last;
    logic        rd_en;

    logic [15:0] dout    [NI];
    logic        vld     [NI];
    logic        dlast   [NI];
    logic        avail   [NI];
    logic [3:0]  nevt    [NI];
    logic        full    [NI];
    logic        ovfl    [NI];
    logic        perr    [NI];
    logic [7:0]  dropcnt [NI];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        push;
        logic [15:0] din;
        logic        last;
        logic        rd;
        logic [15:0] dout;
        logic        vld;
        logic        dl;
        logic [3:0]  nevt;
    } vec_t;

    vec_t        tbl   [$];
    logic [15:0] exp_d [$];
    logic        exp_l [$];

    always #5 clk = ~clk;

    scam_evt_packer #(.TMR(0), .AW(4)) u_dut0 (
        .CLK(clk), .RST_B(rst_b), .PUSH(push), .DIN(din), .LASTWORD(last), .RD_EN(rd_en),
        .DOUT(dout[0]), .DOUT_VLD(vld[0]), .DOUT_LAST(dlast[0]), .EVT_AVAIL(avail[0]),
        .NEVT(nevt[0]), .FULL(full[0]), .OVFL(ovfl[0]), .PROTERR(perr[0]), .DROPCNT(dropcnt[0])
    );

    scam_evt_packer #(.TMR(1), .AW(4)) u_dut1 (
        .CLK(clk), .RST_B(rst_b), .PUSH(push), .DIN(din), .LASTWORD(last), .RD_EN(rd_en),
        .DOUT(dout[1]), .DOUT_VLD(vld[1]), .DOUT_LAST(dlast[1]), .EVT_AVAIL(avail[1]),
        .NEVT(nevt[1]), .FULL(full[1]), .OVFL(ovfl[1]), .PROTERR(perr[1]), .DROPCNT(dropcnt[1])
    );

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %h expected %h", nm, inst, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [15:0] e_dout, input logic e_vld,
                            input logic e_last, input logic [3:0] e_nevt);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_dout"}, i, dout[i], e_dout);
            chk({nm, "_vld"}, i, 16'(vld[i]), 16'(e_vld));
            chk({nm, "_last"}, i, 16'(dlast[i]), 16'(e_last));
            chk({nm, "_nevt"}, i, 16'(nevt[i]), 16'(e_nevt));
            chk({nm, "_avail"}, i, 16'(avail[i]), 16'(e_nevt != 4'h0));
        end
    endtask

    task automatic chk_stat(input string nm, input logic e_full, input logic e_ovfl,
                            input logic e_perr, input logic [7:0] e_drop);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_full"}, i, 16'(full[i]), 16'(e_full));
            chk({nm, "_ovfl"}, i, 16'(ovfl[i]), 16'(e_ovfl));
            chk({nm, "_proterr"}, i, 16'(perr[i]), 16'(e_perr));
            chk({nm, "_dropcnt"}, i, 16'(dropcnt[i]), 16'(e_drop));
        end
    endtask

    function automatic void add(input logic p, input logic [15:0] d, input logic l, input logic r,
                                input logic [15:0] ed, input logic ev, input logic el, input logic [3:0] en);
        vec_t v;
        v.push = p; v.din = d; v.last = l; v.rd = r;
        v.dout = ed; v.vld = ev; v.dl = el; v.nevt = en;
        tbl.push_back(v);
    endfunction

    function automatic void expect_w(input logic [15:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [15:0] d, input logic l);
        push = 1'b1; din = d; last = l;
        tick(1);
        push = 1'b0; din = 16'h0000; last = 1'b0;
    endtask

    task automatic run_rows(input int a, input int b);
        for (int r = a; r < b; r++) begin
            push = tbl[r].push; din = tbl[r].din; last = tbl[r].last; rd_en = tbl[r].rd;
            tick(1);
            chk_outs($sformatf("row%0d", r), tbl[r].dout, tbl[r].vld, tbl[r].dl, tbl[r].nevt);
        end
        push = 1'b0; din = 16'h0000; last = 1'b0; rd_en = 1'b0;
    endtask

    // Pops n words at full rate, comparing each against the expected queue
    task automatic drain(input int n);
        rd_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            while (vld[0] !== 1'b1 && w < 10) begin
                tick(1);
                w++;
            end
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("drain%0d_vld", k), i, 16'(vld[i]), 16'h0001);
                chk($sformatf("drain%0d_dout", k), i, dout[i], exp_d[0]);
                chk($sformatf("drain%0d_last", k), i, 16'(dlast[i]), 16'(exp_l[0]));
            end
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            tick(1);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; push = 1'b0; din = 16'h0000; last = 1'b0; rd_en = 1'b0;

        // Three-word event read out as it arrives (rows 0..7)
        add(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0);
        add(1'b1, 16'h00FF, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 4'd0);
        add(1'b1, 16'h8001, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'hE003, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h92CA, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0);
        // Back-to-back events; row 14 has the trailer write and tag pop together (rows 8..21)
        add(1'b1, 16'h00A1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A1, 1'b1, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h00A1, 1'b1, 1'b0, 4'd1);
        add(1'b1, 16'h00B1, 1'b0, 1'b1, 16'hE001, 1'b1, 1'b0, 4'd1);
        add(1'b1, 16'h00B2, 1'b1, 1'b0, 16'hE001, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A1, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h00B1, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'h00B1, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h00B2, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'hE002, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 16'hE002, 1'b1, 1'b0, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 4'd1);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0);

        tick(3);
        chk_outs("reset", 16'h0000, 1'b0, 1'b0, 4'd0);
        chk_stat("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_b = 1'b1;

        run_rows(0, 8);
        chk_stat("t1", 1'b0, 1'b0, 1'b0, 8'd0);

        // 20-word event into a 16-deep FIFO with no reads: 14 stored, then both trailers
        for (int k = 1; k <= 20; k++) begin
            push_word(16'h1000 | 16'(k), (k == 20));
        end
        tick(3);
        chk_outs("t2", 16'h1001, 1'b1, 1'b0, 4'd1);
        chk_stat("t2", 1'b1, 1'b1, 1'b0, 8'd0);

        // Event arriving while full is dropped whole; after 4 pops a new one fits
        push_word(16'h5555, 1'b1);
        tick(2);
        chk_outs("t3_drop", 16'h1001, 1'b1, 1'b0, 4'd1);
        chk_stat("t3_drop", 1'b1, 1'b1, 1'b0, 8'd1);
        for (int k = 1; k <= 4; k++) expect_w(16'h1000 | 16'(k), 1'b0);
        drain(4);
        chk_stat("t3_pop", 1'b0, 1'b1, 1'b0, 8'd1);
        push_word(16'hAAAA, 1'b1);
        tick(3);
        chk_outs("t3_acc", 16'h1005, 1'b1, 1'b0, 4'd2);
        for (int k = 5; k <= 14; k++) expect_w(16'h1000 | 16'(k), 1'b0);
        expect_w(16'hF014, 1'b0);
        expect_w(16'h0014, 1'b1);
        expect_w(16'hAAAA, 1'b0);
        expect_w(16'hE001, 1'b0);
        expect_w(16'hAAAA, 1'b1);
        drain(15);
        chk_outs("t3_empty", 16'h0000, 1'b0, 1'b0, 4'd0);

        // PUSH one cycle after LASTWORD is ignored and flagged
        push_word(16'h0011, 1'b0);
        push_word(16'h0022, 1'b1);
        push_word(16'h0044, 1'b0);
        tick(3);
        chk_outs("t4", 16'h0011, 1'b1, 1'b0, 4'd1);
        chk_stat("t4", 1'b0, 1'b1, 1'b1, 8'd1);
        expect_w(16'h0011, 1'b0);
        expect_w(16'h0022, 1'b0);
        expect_w(16'hE002, 1'b0);
        expect_w(16'h0033, 1'b1);
        drain(4);
        chk_outs("t4_empty", 16'h0000, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-event with five words held
        push_word(16'h0007, 1'b1);
        tick(2);
        push_word(16'h0101, 1'b0);
        push_word(16'h0102, 1'b0);
        tick(1);
        chk_outs("t5_pre", 16'h0007, 1'b1, 1'b0, 4'd1);
        #3;
        rst_b = 1'b0;
        #1;
        chk_outs("t5_rst", 16'h0000, 1'b0, 1'b0, 4'd0);
        chk_stat("t5_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        tick(1);
        push_word(16'h0001, 1'b1);
        tick(3);
        expect_w(16'h0001, 1'b0);
        expect_w(16'hE001, 1'b0);
        expect_w(16'h0001, 1'b1);
        drain(3);
        chk_outs("t5_empty", 16'h0000, 1'b0, 1'b0, 4'd0);

        run_rows(8, 22);
        chk_stat("t6", 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
